// File: rtl/cnt_gate_ctrl_if.sv
// cnt_gate_ctrl_if: control, event and counter-strobe bundle for the
// gate-window controller. The master side (stimulus / host logic) drives the
// controls and the event line. The slave side (cnt_gate_ctrl) drives the
// counter strobes and busy.
interface cnt_gate_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             abort;
  logic             cont;
  logic [WIDTH-1:0] win_len;
  logic             evt_in;
  logic             ena_out;
  logic             srst_out;
  logic             latch_out;
  logic             busy;

  modport master (
    output start, abort, cont, win_len, evt_in,
    input  ena_out, srst_out, latch_out, busy
  );

  modport slave (
    input  start, abort, cont, win_len, evt_in,
    output ena_out, srst_out, latch_out, busy
  );
endinterface

// File: rtl/cnt_gate_ctrl.sv
// cnt_gate_ctrl: gate-window controller for the enable/sync-reset event counter.
// It synchronizes evt_in and converts each rising edge into a one-cycle count
// enable. Enables are produced only inside a measurement window of len_q
// cycles. A clear strobe is issued before each window, and a latch strobe is
// issued after it.
// Optional feature macro: CNT_GATE_CTRL_DEGLITCH_EN. When it is defined, an
// event must be seen high on two consecutive synchronized samples before it
// counts.
module cnt_gate_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  cnt_gate_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, OPEN, LATCH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] timer_q, timer_d;
  logic             ena_q, ena_d;
  logic             edge_w;

`ifdef CNT_GATE_CTRL_DEGLITCH_EN
  logic s1_q, s2_q, s4_q, s5_q;

  // Two-flop synchronizer. s4 adds a second confirming sample, and s5 holds
  // the qualified level from the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s4_q <= 1'b0;
      s5_q <= 1'b0;
    end else begin
      s1_q <= bus.evt_in;
      s2_q <= s1_q;
      s4_q <= s2_q;
      s5_q <= s2_q & s4_q;
    end
  end

  assign edge_w = s2_q & s4_q & ~s5_q;
`else
  logic s1_q, s2_q, s3_q;

  // Two-flop synchronizer, followed by a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.evt_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_w = s2_q & ~s3_q;
`endif

  // Registers for the window state, the window length, the timer and the
  // count enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= WIDTH'(1);
      timer_q <= '0;
      ena_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      ena_q   <= ena_d;
    end
  end

  // Next-state logic. An edge that occurs in the final OPEN cycle still
  // counts, because ena lands one cycle later, in LATCH. Abort overrides
  // everything else.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    timer_d = timer_q;
    ena_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CLEAR;
          len_d   = (bus.win_len == '0) ? WIDTH'(1) : bus.win_len;
        end
      end
      CLEAR: begin
        timer_d = len_q - WIDTH'(1);
        state_d = OPEN;
      end
      OPEN: begin
        ena_d = edge_w;
        if (timer_q == '0) state_d = LATCH;
        else               timer_d = timer_q - WIDTH'(1);
      end
      LATCH: begin
        state_d = bus.cont ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      len_d   = len_q;
      ena_d   = 1'b0;
    end
  end

  assign bus.ena_out   = ena_q;
  assign bus.srst_out  = (state_q == CLEAR);
  assign bus.latch_out = (state_q == LATCH);
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/cnt_gate_ctrl.md
# cnt_gate_ctrl

Gate-window controller that sits directly upstream of the team's enable/sync-reset event counter. It synchronizes an asynchronous event line and turns each rising edge into a one-cycle count enable, but only inside a programmable measurement window. It issues a one-cycle synchronous clear before each window and a one-cycle latch strobe when the window closes, so the counter output can be captured as a rate sample.

## Interface
- WIDTH, 16, width of the window-length register and window timer
- clk  input  1  module clock, rising edge
- rst_n  input  1  asynchronous reset, active low; clock and reset are fixed as one clock with asynchronous active-low reset
- start  input  1  arm pulse; sampled only in IDLE
- abort  input  1  abandon current window; highest priority after reset
- cont  input  1  continuous mode; sampled at the end of each window
- win_len  input  WIDTH  window length in clk cycles; sampled when start is accepted
- evt_in  input  1  asynchronous event line
- ena_out  output  1  one-cycle count enable to counter ena
- srst_out  output  1  one-cycle clear to counter srst
- latch_out  output  1  one-cycle strobe; downstream captures counter dout
- busy  output  1  high in any state other than IDLE

## Operation
- Synchronizer: evt_in passes through 2 flops (s1, s2), then a history flop s3. The edge term is s2 & ~s3.
- States: IDLE, CLEAR, OPEN, LATCH.
- IDLE:
  - start=1 -> CLEAR.
  - win_len is loaded into len_r; a value of 0 is loaded as 1.
- CLEAR:
  - srst_out=1 for this cycle.
  - The timer is loaded with len_r-1.
  - Next state is OPEN.
- OPEN:
  - ena_out=1 in the cycle after each edge term seen in OPEN.
  - The timer decrements each cycle; when it reaches 0 the next state is LATCH.
  - OPEN lasts exactly len_r cycles.
- LATCH:
  - latch_out=1 for this cycle.
  - cont=1 -> CLEAR, reusing len_r (win_len is not resampled).
  - cont=0 -> IDLE.
- abort=1 in any state:
  - Next state is IDLE.
  - No latch_out is issued, and ena_out is forced to 0 on the next cycle.
- start while busy is ignored. start and abort asserted together in IDLE: abort wins and the block stays IDLE.
- Edge gating: an edge term present in the last OPEN cycle still produces ena_out, which lands in the LATCH cycle. The counter increment and latch therefore coincide, so the downstream captures on the cycle after latch_out. Edge terms in CLEAR, LATCH or IDLE are dropped.
- At most one ena_out per evt_in rising edge. evt_in held high gives a single enable.
- Timer is WIDTH bits and decrements only; there is no wrap-around.

## Timing
- Reset values: ena_out=0, srst_out=0, latch_out=0, busy=0; state=IDLE, s1=s2=s3=0, len_r=1, timer=0.
- start sampled at edge t: srst_out high in cycle t+1; OPEN for cycles t+2 .. t+1+len_r; latch_out high in cycle t+2+len_r.
- Continuous mode: window period is len_r+2 cycles (CLEAR + OPEN + LATCH).
- evt_in first sampled high at edge k: ena_out high in cycle k+3, provided the edge term (cycle k+2) falls in OPEN. Add one cycle with deglitch enabled.
- Reset asserted mid-window: all outputs drop to 0 immediately (asynchronous). After release, the first start is accepted on the first clk edge.
- busy rises in the cycle after start is accepted and falls in the cycle after LATCH, or after abort.

## Configuration
- CNT_GATE_CTRL_DEGLITCH_EN defined:
  - A 4th flop s4 is added after s2.
  - The edge term becomes s2 & s4 & ~s5, where s5 is the history of s2 & s4.
  - evt_in must be high for 2 consecutive synchronized samples to count.
  - Latency grows by 1 cycle and 1-cycle pulses are rejected.
- Undefined: no deglitch; any synchronized high sample after low counts. Latency is as given under Timing.

## Test plan
- Reset value and single window:
  - Stimulus: rst_n low for 3 cycles, then release; start with win_len=10, cont=0, evt_in idle.
  - Response: all outputs 0 during reset; srst_out at t+1; busy high for 12 cycles; latch_out at t+12; zero ena_out.
- Event counting:
  - Stimulus: win_len=20; 5 evt_in pulses, each 3 cycles high and 3 low, fully inside OPEN.
  - Response: exactly 5 ena_out pulses, each 3 cycles after evt_in rises. One extra pulse placed entirely in CLEAR gives no ena_out.
- Continuous mode:
  - Stimulus: cont=1, win_len=4; change win_len to 9 after start.
  - Response: latch_out every 6 cycles with srst_out immediately following; window stays at 4. Dropping cont returns to IDLE after the next latch_out.
- Abort and corner cases:
  - abort in mid-OPEN: no latch_out, busy low next cycle.
  - start and abort in the same IDLE cycle: block stays IDLE.
  - win_len=0: OPEN lasts 1 cycle.
- Boundaries:
  - Edge term in the last OPEN cycle: ena_out in the same cycle as latch_out.
  - evt_in held high for 50 cycles: exactly 1 ena_out.
  - With CNT_GATE_CTRL_DEGLITCH_EN, a 1-cycle evt_in pulse: 0 ena_out.
